// File: rtl/usb_fs_pkg.sv
// Shared definitions for the full-speed USB receive front-end.
// Holds the receive FSM state type, the {D-,D+} line-state encodings,
// the bit-stuffing run length and the phase at which the recovered
// clock samples the line.
package usb_fs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERR
  } rx_state_t;

  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE0 = 2'b00;

  localparam int unsigned BIT_STUFF_LEN = 6;
  localparam int unsigned SAMPLE_PHASE  = 2;

endpackage

// File: rtl/usb_fs_rx_dpll.sv
// Input synchroniser, line-state filter and 4x oversampled clock recovery.
// Ports:
//   clk, rst_n    : 48 MHz clock, async active-low reset
//   rcv, dp, dn   : raw asynchronous pad receiver outputs
//   sample_stb    : one-cycle mid-bit sample strobe
//   rcv_s         : synchronised differential receiver output
//   se0_s         : synchronised SE0 (dp = dn = 0)
//   ls_s          : filtered line state {D-, D+}
module usb_fs_rx_dpll
  import usb_fs_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rcv,
  input  logic       dp,
  input  logic       dn,
  output logic       sample_stb,
  output logic       rcv_s,
  output logic       se0_s,
  output logic [1:0] ls_s
);

  logic       rcv_m;
  logic       dp_m;
  logic       dn_m;
  logic       dp_s;
  logic       dn_s;
  logic [1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcv_m <= 1'b0;
      rcv_s <= 1'b0;
      dp_m  <= 1'b0;
      dp_s  <= 1'b0;
      dn_m  <= 1'b0;
      dn_s  <= 1'b0;
      ls_s  <= LS_SE0;
      phase <= '0;
    end else begin
      rcv_m <= rcv;
      rcv_s <= rcv_m;
      dp_m  <= dp;
      dp_s  <= dp_m;
      dn_m  <= dn;
      dn_s  <= dn_m;
      // Both synchroniser stages agreeing means the level held for two
      // consecutive cycles; only then is the line state updated.
      if ({dn_m, dp_m} == {dn_s, dp_s}) begin
        ls_s <= {dn_s, dp_s};
      end
      // Edge seen between the stages: phase is 0 in the same cycle the
      // new level appears on rcv_s, so the strobe lands 2 cycles later.
      if (rcv_m != rcv_s) begin
        phase <= '0;
      end else if (phase == 2'(OVERSAMPLE - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + 2'd1;
      end
    end
  end

  assign sample_stb = (phase == 2'(SAMPLE_PHASE));
  assign se0_s      = ~dp_s & ~dn_s;

endmodule

// File: rtl/usb_fs_rx.sv
// Full-speed USB receive front-end: NRZI decode, SYNC detection,
// bit-unstuffing, byte assembly and EOP detection, UTMI receive side.
// Ports:
//   usb_clk_i, usb_rstn_i      : 48 MHz clock, async active-low reset
//   rx_en_i                    : receive enable (low aborts reception)
//   rx_rcv_i, rx_dp_i, rx_dn_i : asynchronous pad receiver outputs
//   utmi_data_o                : last received byte
//   utmi_rxvalid_o             : one-cycle strobe, utmi_data_o updated
//   utmi_rxactive_o            : high from SYNC to EOP/abort
//   utmi_rxerror_o             : one-cycle error strobe
//   utmi_linestate_o           : filtered {D-, D+}
module usb_fs_rx
  import usb_fs_pkg::*;
#(
  parameter int unsigned OVERSAMPLE       = 4,
  parameter int unsigned SYNC_MIN_ZEROS   = 3,
  parameter int unsigned EOP_TIMEOUT_BITS = 8
) (
  input  logic       usb_clk_i,
  input  logic       usb_rstn_i,
  input  logic       rx_en_i,
  input  logic       rx_rcv_i,
  input  logic       rx_dp_i,
  input  logic       rx_dn_i,
  output logic [7:0] utmi_data_o,
  output logic       utmi_rxvalid_o,
  output logic       utmi_rxactive_o,
  output logic       utmi_rxerror_o,
  output logic [1:0] utmi_linestate_o
);

  logic       sample_stb;
  logic       rcv_s;
  logic       se0_s;
  logic [1:0] ls_s;

  usb_fs_rx_dpll #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_dpll (
    .clk       (usb_clk_i),
    .rst_n     (usb_rstn_i),
    .rcv       (rx_rcv_i),
    .dp        (rx_dp_i),
    .dn        (rx_dn_i),
    .sample_stb(sample_stb),
    .rcv_s     (rcv_s),
    .se0_s     (se0_s),
    .ls_s      (ls_s)
  );

  assign utmi_linestate_o = ls_s;

  rx_state_t  state, state_n;
  logic       last_rcv, last_rcv_n;
  logic [3:0] zero_cnt, zero_cnt_n;
  logic [2:0] one_cnt, one_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       se0_seen, se0_seen_n;
  logic [7:0] data_n;
  logic       valid_n, active_n, error_n;
  logic       nrzi_bit;
  logic       is_j, is_k;

  assign nrzi_bit = (rcv_s == last_rcv);
  assign is_j     = (ls_s == LS_J);
  assign is_k     = (ls_s == LS_K);

  always_comb begin
    state_n    = state;
    last_rcv_n = last_rcv;
    zero_cnt_n = zero_cnt;
    one_cnt_n  = one_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tmo_cnt_n  = tmo_cnt;
    se0_seen_n = se0_seen;
    data_n     = utmi_data_o;
    valid_n    = 1'b0;
    error_n    = 1'b0;
    active_n   = utmi_rxactive_o;

    if (!rx_en_i) begin
      state_n    = IDLE;
      active_n   = 1'b0;
      zero_cnt_n = '0;
      one_cnt_n  = '0;
      bit_cnt_n  = '0;
      tmo_cnt_n  = '0;
      se0_seen_n = 1'b0;
    end else if (sample_stb) begin
      last_rcv_n = rcv_s;
      unique case (state)
        IDLE: begin
          zero_cnt_n = '0;
          one_cnt_n  = '0;
          if (is_k) state_n = SYNC;
        end
        SYNC: begin
          if (se0_s) begin
            state_n = IDLE;
          end else if (!nrzi_bit) begin
            if (zero_cnt != '1) zero_cnt_n = zero_cnt + 4'd1;
          end else if (zero_cnt >= 4'(SYNC_MIN_ZEROS)) begin
            state_n   = DATA;
            active_n  = 1'b1;
            one_cnt_n = '0;
            bit_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          if (se0_s) begin
            state_n = EOP;
            if (bit_cnt >= 3'd2) error_n = 1'b1;
          end else if (one_cnt == 3'(BIT_STUFF_LEN)) begin
            // Stuff bit slot: a 0 is dropped, a 1 is a stuffing violation.
            if (nrzi_bit) begin
              error_n    = 1'b1;
              state_n    = ERR;
              tmo_cnt_n  = '0;
              se0_seen_n = 1'b0;
            end else begin
              one_cnt_n = '0;
            end
          end else begin
            shift_n   = {nrzi_bit, shift[7:1]};
            one_cnt_n = nrzi_bit ? one_cnt + 3'd1 : '0;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_n  = shift_n;
              valid_n = 1'b1;
            end
          end
        end
        EOP: begin
          if (is_j) begin
            state_n  = IDLE;
            active_n = 1'b0;
          end else if (is_k) begin
            error_n    = 1'b1;
            state_n    = ERR;
            tmo_cnt_n  = '0;
            se0_seen_n = 1'b0;
          end
        end
        ERR: begin
          if (se0_s) begin
            se0_seen_n = 1'b1;
            tmo_cnt_n  = '0;
          end else if ((se0_seen && is_j) || (tmo_cnt == 8'(EOP_TIMEOUT_BITS - 1))) begin
            state_n  = IDLE;
            active_n = 1'b0;
          end else begin
            tmo_cnt_n = tmo_cnt + 8'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge usb_clk_i or negedge usb_rstn_i) begin
    if (!usb_rstn_i) begin
      state           <= IDLE;
      last_rcv        <= 1'b1;
      zero_cnt        <= '0;
      one_cnt         <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      tmo_cnt         <= '0;
      se0_seen        <= 1'b0;
      utmi_data_o     <= '0;
      utmi_rxvalid_o  <= 1'b0;
      utmi_rxactive_o <= 1'b0;
      utmi_rxerror_o  <= 1'b0;
    end else begin
      state           <= state_n;
      last_rcv        <= last_rcv_n;
      zero_cnt        <= zero_cnt_n;
      one_cnt         <= one_cnt_n;
      bit_cnt         <= bit_cnt_n;
      shift           <= shift_n;
      tmo_cnt         <= tmo_cnt_n;
      se0_seen        <= se0_seen_n;
      utmi_data_o     <= data_n;
      utmi_rxvalid_o  <= valid_n;
      utmi_rxactive_o <= active_n;
      utmi_rxerror_o  <= error_n;
    end
  end

endmodule

// File: tb/tb_usb_fs_rx.sv
// Directed testbench for usb_fs_rx: drives NRZI/bit-stuffed packets on the
// pad inputs and checks received bytes, strobes and line state.
module tb_usb_fs_rx;

  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       rcv = 1'b1;
  logic       dp = 1'b1;
  logic       dn = 1'b0;
  logic [7:0] data;
  logic       rxvalid;
  logic       rxactive;
  logic       rxerror;
  logic [1:0] ls;

  always #10 clk = ~clk;

  usb_fs_rx #(
    .OVERSAMPLE      (4),
    .SYNC_MIN_ZEROS  (3),
    .EOP_TIMEOUT_BITS(8)
  ) dut (
    .usb_clk_i       (clk),
    .usb_rstn_i      (rst_n),
    .rx_en_i         (rx_en),
    .rx_rcv_i        (rcv),
    .rx_dp_i         (dp),
    .rx_dn_i         (dn),
    .utmi_data_o     (data),
    .utmi_rxvalid_o  (rxvalid),
    .utmi_rxactive_o (rxactive),
    .utmi_rxerror_o  (rxerror),
    .utmi_linestate_o(ls)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor
  logic [7:0]  rx_q[$];
  int unsigned err_pulses = 0;
  int unsigned long_err = 0;
  int unsigned bad_act = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned fall_cyc = 0;
  logic        act_prev = 1'b0;
  logic        err_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxvalid) begin
      rx_q.push_back(data);
      if (!rxactive) bad_act++;
    end
    if (rxerror) begin
      err_pulses++;
      if (err_prev) long_err++;
      if (!rxactive) bad_act++;
    end
    if (rxactive && !act_prev) rise_cyc = cyc;
    if (!rxactive && act_prev) fall_cyc = cyc;
    act_prev = rxactive;
    err_prev = rxerror;
  end

  function automatic logic [7:0] q_at(input int unsigned i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  // Line encoder
  logic        level = 1'b1;
  int unsigned ones = 0;
  bit          jitter = 1'b0;
  bit          jphase = 1'b0;
  int unsigned sync_end = 0;
  int unsigned j_start = 0;

  task automatic drive_sym(input logic [1:0] s);
    int unsigned per;
    {dn, dp} = s;
    rcv = (s == J);
    per = 4;
    if (jitter) begin
      per = jphase ? 5 : 3;
      jphase = ~jphase;
    end
    repeat (per) @(negedge clk);
  endtask

  task automatic nrzi_raw(input bit b);
    if (!b) level = ~level;
    drive_sym(level ? J : K);
  endtask

  task automatic tx_bit(input bit b);
    nrzi_raw(b);
    if (b) begin
      ones++;
      if (ones == 6) begin
        nrzi_raw(1'b0);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic tx_sync();
    level = 1'b1;
    for (int i = 0; i < 7; i++) nrzi_raw(1'b0);
    nrzi_raw(1'b1);
    ones = 0;
    sync_end = cyc;
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_bit(v[i]);
  endtask

  task automatic tx_eop();
    drive_sym(SE0);
    drive_sym(SE0);
    j_start = cyc;
    drive_sym(J);
    level = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    err_pulses = 0;
    long_err = 0;
    bad_act = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", rxvalid, 1'b0);
    check("rst_active", rxactive, 1'b0);
    check("rst_error", rxerror, 1'b0);
    check("rst_ls", ls, 2'b00);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("ls_idle_j", ls, J);

    // Linestate latency: 3 cycles from pad change
    {dn, dp} = K;
    rcv = 1'b0;
    repeat (2) @(negedge clk);
    check("ls_lat2", ls, J);
    @(negedge clk);
    check("ls_lat3", ls, K);
    {dn, dp} = J;
    rcv = 1'b1;
    repeat (8) @(negedge clk);
    rx_en = 1'b1;
    repeat (8) @(negedge clk);

    // Single byte 0xA5
    clear_mon();
    tx_sync();
    tx_byte(8'hA5);
    check("a5_act_mid", rxactive, 1'b1);
    tx_eop();
    check("a5_rise", rise_cyc - sync_end, 1);
    check("a5_fall", fall_cyc - j_start, 5);
    check("a5_cnt", rx_q.size(), 1);
    check("a5_data", q_at(0), 8'hA5);
    check("a5_err", err_pulses, 0);
    check("a5_act_end", rxactive, 1'b0);

    // Bit stuffing across 0xFF 0x7F
    clear_mon();
    tx_sync();
    tx_byte(8'hFF);
    tx_byte(8'h7F);
    tx_eop();
    check("stuff_cnt", rx_q.size(), 2);
    check("stuff_b0", q_at(0), 8'hFF);
    check("stuff_b1", q_at(1), 8'h7F);
    check("stuff_err", err_pulses, 0);

    // Seven ones: stuff error, exit via SE0 then J
    clear_mon();
    tx_sync();
    for (int i = 0; i < 7; i++) nrzi_raw(1'b1);
    tx_eop();
    check("serr_err", err_pulses, 1);
    check("serr_valid", rx_q.size(), 0);
    check("serr_act_end", rxactive, 1'b0);

    // Stuff error with no SE0: timeout after 8 strobes
    clear_mon();
    tx_sync();
    for (int i = 0; i < 7; i++) nrzi_raw(1'b1);
    for (int i = 0; i < 6; i++) drive_sym(J);
    check("tmo_act_hold", rxactive, 1'b1);
    for (int i = 0; i < 4; i++) drive_sym(J);
    level = 1'b1;
    check("tmo_act_drop", rxactive, 1'b0);
    check("tmo_err", err_pulses, 1);

    // SE0 after 3 bits of second byte
    clear_mon();
    tx_sync();
    tx_byte(8'h3C);
    for (int i = 0; i < 3; i++) tx_bit(1'b0);
    tx_eop();
    check("part3_cnt", rx_q.size(), 1);
    check("part3_data", q_at(0), 8'h3C);
    check("part3_err", err_pulses, 1);

    // One dribble bit tolerated
    clear_mon();
    tx_sync();
    tx_byte(8'hC3);
    tx_bit(1'b1);
    tx_eop();
    check("drib_cnt", rx_q.size(), 1);
    check("drib_data", q_at(0), 8'hC3);
    check("drib_err", err_pulses, 0);

    // Abort mid-byte
    clear_mon();
    tx_sync();
    for (int i = 0; i < 4; i++) tx_bit(i[0]);
    check("abort_act_pre", rxactive, 1'b1);
    rx_en = 1'b0;
    @(negedge clk);
    check("abort_act_next", rxactive, 1'b0);
    for (int i = 0; i < 4; i++) tx_bit(1'b0);
    tx_eop();
    rx_en = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_valid", rx_q.size(), 0);
    check("abort_err", err_pulses, 0);

    // Jittered bit periods (3/5 cycles), counting pattern
    clear_mon();
    jitter = 1'b1;
    jphase = 1'b0;
    tx_sync();
    for (int i = 0; i < 64; i++) tx_byte(8'(i));
    tx_eop();
    jitter = 1'b0;
    check("jit_cnt", rx_q.size(), 64);
    for (int i = 0; i < 64; i++) check($sformatf("jit_b%0d", i), q_at(i), 8'(i));
    check("jit_err", err_pulses, 0);

    // Strobe integrity over all packets above
    check("err_single", long_err, 0);
    check("strobe_in_act", bad_act, 0);

    // Asynchronous reset mid-packet
    clear_mon();
    tx_sync();
    tx_byte(8'h96);
    tx_bit(1'b1);
    check("arst_pre_data", data, 8'h96);
    #3 rst_n = 1'b0;
    #1;
    check("arst_act", rxactive, 1'b0);
    check("arst_data", data, 8'h00);
    check("arst_ls", ls, 2'b00);
    {dn, dp} = J;
    rcv = 1'b1;
    level = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_ls_after", ls, J);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_fs_rx.md
# usb_fs_rx

Full-speed USB receive front-end for the USB1.1 host path. It sits between the pad transceiver outputs (rcv/dp/dn) and the UTMI receive inputs of the host core, all in the 48 MHz `usb_clk_i` domain. It does the following:
- input synchronisation;
- line-state filtering;
- 4x oversampled clock recovery;
- NRZI decode, SYNC detection and bit-unstuffing;
- byte assembly and EOP detection.

It produces UTMI `rxactive`/`rxvalid`/`rxerror`/`data`/`linestate`.

## Interface

Parameters:
- `OVERSAMPLE`, default 4: clock cycles per bit. Only 4 is supported at 48 MHz / 12 Mbps.
- `SYNC_MIN_ZEROS`, default 3: minimum decoded zeros preceding the SYNC terminating '1'.
- `EOP_TIMEOUT_BITS`, default 8: bit times allowed in `ERR` before forced return to `IDLE`.

Ports:
- `usb_clk_i` in 1: 48 MHz clock.
- `usb_rstn_i` in 1: active-low reset, asynchronous assert. One clock; reset is asynchronous and active-low.
- `rx_en_i` in 1: receive enable. Driven low by the PHY while transmitting.
- `rx_rcv_i` in 1: differential receiver output, async.
- `rx_dp_i` in 1: single-ended D+, async.
- `rx_dn_i` in 1: single-ended D-, async.
- `utmi_data_o` out 8: received byte, LSB first on the wire.
- `utmi_rxvalid_o` out 1: one-cycle strobe, `utmi_data_o` valid.
- `utmi_rxactive_o` out 1: high from SYNC detected to EOP/abort.
- `utmi_rxerror_o` out 1: one-cycle error strobe.
- `utmi_linestate_o` out 2: {D-, D+} filtered. J=2'b01, K=2'b10, SE0=2'b00.

## Operation

- Reset values: `utmi_data_o`=0, `utmi_rxvalid_o`=0, `utmi_rxactive_o`=0, `utmi_rxerror_o`=0, `utmi_linestate_o`=2'b00. FSM starts in `IDLE`, all counters 0.
- Sync: `rcv`, `dp` and `dn` each pass through 2 flops.
- Linestate filter: `utmi_linestate_o` updates only when the synced {dn,dp} equals its previous-cycle value.
- Clock recovery:
  - 2-bit phase counter, increments modulo 4.
  - Forced to 0 on every edge of synced `rcv`.
  - Sample strobe fires when phase==2.
  - With no edges it free-runs, so bit periods are still produced during long runs of ones.
- NRZI: decoded bit = 1 if the sampled `rcv` equals the previous sample, else 0.
- SE0: SE0 at a sample strobe (synced dp=dn=0) counts as SE0, not data.

FSM:
- `IDLE`:
  - Waits for a K at a sample strobe while `rx_en_i`=1, then goes to `SYNC`.
  - Zero/one counters clear.
- `SYNC`:
  - Counts consecutive decoded zeros.
  - A decoded 1 with zero-count ≥ `SYNC_MIN_ZEROS` asserts `utmi_rxactive_o` and goes to `DATA`.
  - A decoded 1 with fewer zeros, or SE0, returns to `IDLE`.
- `DATA`:
  - Shifts decoded bits into the byte register LSB first; 3-bit bit counter.
  - Ones counter: counts consecutive decoded 1s.
    - After 6 ones, the next bit is a stuff bit: discarded if 0.
    - If that bit is 1: stuff error. Pulse `rxerror` and go to `ERR`.
  - On the 8th bit: load `utmi_data_o`, pulse `utmi_rxvalid_o`.
  - SE0 goes to `EOP`. If the bit counter ≥2 at SE0, pulse `rxerror` (1 dribble bit tolerated, partial bits discarded).
- `EOP`:
  - J at a sample strobe: deassert `rxactive`, go to `IDLE`.
  - K: pulse `rxerror`, go to `ERR`.
- `ERR`:
  - `rxactive` stays high.
  - Exits to `IDLE` (`rxactive` low) on SE0 followed by J, or after `EOP_TIMEOUT_BITS` sample strobes with no SE0.
- Abort: `rx_en_i` low in any state forces `IDLE` next cycle. `rxactive` drops, no `rxerror`, no `rxvalid`.
- Simultaneous events:
  - 8th bit and stuff error on the same strobe cannot coincide; the stuff bit is not counted.
  - Abort has priority over everything.

## Timing

- Pad change to `utmi_linestate_o`: 3 cycles (2 sync + 1 filter).
- Sample strobe is 2 cycles after the recovered edge, i.e. mid-bit.
- `utmi_rxactive_o` rises 1 cycle after the strobe that samples the SYNC final bit.
- `utmi_rxvalid_o`/`utmi_data_o` are registered 1 cycle after the strobe of the byte's last bit. Strobes are ≥32 cycles apart; `utmi_data_o` holds until the next byte.
- `utmi_rxactive_o` falls 1 cycle after the J strobe following SE0.
- `utmi_rxerror_o` is always a single-cycle pulse.
- Asynchronous reset mid-packet: all outputs go to reset values immediately.

## Structure

- Package `usb_fs_pkg` holds:
  - the FSM enum (`IDLE`, `SYNC`, `DATA`, `EOP`, `ERR`);
  - linestate constants `LS_J`, `LS_K`, `LS_SE0`;
  - `BIT_STUFF_LEN`=6;
  - `SAMPLE_PHASE`=2.
- Sub-module `usb_fs_rx_dpll` contains the synchroniser, edge detect, phase counter and sample strobe. It outputs `sample_stb`, `rcv_s`, `se0_s`, `ls_s`.
- The top contains the FSM, NRZI, unstuffing and byte assembly.

## Test plan

- Idle J, then SYNC KJKJKJKK, then byte 0xA5, then SE0 SE0 J → one `rxvalid` with data=0xA5. `rxactive` is high from SYNC+1 cycle to J+1 cycle. No `rxerror`.
- Byte 0xFF 0x7F, requiring a stuff bit after 6 ones → `rxvalid` with 0xFF then 0x7F. Stuff bits are removed.
- Seven consecutive 1s (stuff bit = 1) → one `rxerror` pulse, FSM in `ERR`, then back to `IDLE` after SE0→J. No further `rxvalid`.
- SE0 after 3 bits of the second byte → one `rxvalid` (first byte) and one `rxerror`. With 1 dribble bit instead → no `rxerror`.
- `rx_en_i` dropped mid-byte → `rxactive` low next cycle, no `rxvalid`/`rxerror`.
- Bit period jitter ±1 cycle (edges at 3/5-cycle spacing) over a 64-byte counting pattern 0x00..0x3F → all bytes received correctly.
